// File: rtl/divide.sv
// Sequential 8-bit by 4-bit unsigned restoring divider with a nibble-wide
// load/read port; one quotient bit per DIV_CLK cycle, 8 cycles per divide.
module divide (
  input  logic DIV_CLK,
  input  logic RST_N,
  input  logic DIN0,
  input  logic DIN1,
  input  logic DIN2,
  input  logic DIN3,
  input  logic LOAD,
  input  logic SEL0,
  input  logic SEL1,
  output logic R0,
  output logic R1,
  output logic R2,
  output logic R3,
  output logic BUSY
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [7:0]  dvd;
  logic [3:0]  divr;
  logic [7:0]  w;
  logic [4:0]  p;
  logic [2:0]  cnt;
  logic [7:0]  q;
  logic [3:0]  rem;
  logic        doneFlag;
  logic        divz;

  logic [3:0]  din;
  logic [1:0]  sel;
  logic [4:0]  t;
  logic        qBit;
  logic [4:0]  pNext;
  logic [7:0]  wNext;
  logic [3:0]  rdNibble;

  assign din = {DIN3, DIN2, DIN1, DIN0};
  assign sel = {SEL1, SEL0};

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor whenever it fits.
  assign t     = {p[3:0], w[7]};
  assign qBit  = (t >= {1'b0, divr});
  assign pNext = qBit ? (t - {1'b0, divr}) : t;
  assign wNext = {w[6:0], qBit};

  assign BUSY = (state == RUN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the async reset clears all of them.
  always_ff @(posedge DIV_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      dvd      <= '0;
      divr     <= '0;
      w        <= '0;
      p        <= '0;
      cnt      <= '0;
      q        <= '0;
      rem      <= '0;
      doneFlag <= 1'b0;
      divz     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          w   <= wNext;
          p   <= pNext;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            q        <= wNext;
            rem      <= pNext[3:0];
            doneFlag <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          // Loads are only honoured outside RUN, so a busy divide is never disturbed.
          if (LOAD) begin
            case (sel)
              2'd0: begin
                dvd[3:0] <= din;
                doneFlag <= 1'b0;
                divz     <= 1'b0;
              end
              2'd1: begin
                dvd[7:4] <= din;
                doneFlag <= 1'b0;
                divz     <= 1'b0;
              end
              2'd2: begin
                divr <= din;
                if (din == 4'd0) begin
                  q        <= 8'hFF;
                  rem      <= 4'h0;
                  divz     <= 1'b1;
                  doneFlag <= 1'b1;
                  state    <= DONE;
                end else begin
                  w        <= dvd;
                  p        <= '0;
                  cnt      <= '0;
                  divz     <= 1'b0;
                  doneFlag <= 1'b0;
                  state    <= RUN;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    rdNibble = 4'h0;
    case (sel)
      2'd0:    rdNibble = q[3:0];
      2'd1:    rdNibble = q[7:4];
      2'd2:    rdNibble = rem;
      default: rdNibble = {1'b0, divz, BUSY, doneFlag};
    endcase
  end

  assign {R3, R2, R1, R0} = rdNibble;

endmodule

// File: tb/tb_divide.sv
// Directed self-checking bench for the nibble-port restoring divider.
module tb_divide;

  logic DIV_CLK = 1'b0;
  logic RST_N = 1'b0;
  logic DIN0 = 0, DIN1 = 0, DIN2 = 0, DIN3 = 0;
  logic LOAD = 0, SEL0 = 0, SEL1 = 0;
  logic R0, R1, R2, R3, BUSY;

  int total = 0;
  int bad   = 0;

  divide dut (
    .DIV_CLK(DIV_CLK), .RST_N(RST_N),
    .DIN0(DIN0), .DIN1(DIN1), .DIN2(DIN2), .DIN3(DIN3),
    .LOAD(LOAD), .SEL0(SEL0), .SEL1(SEL1),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3), .BUSY(BUSY)
  );

  always #5 DIV_CLK = ~DIV_CLK;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setSel(input logic [1:0] s);
    {SEL1, SEL0} = s;
  endtask

  // Present one write strobe for exactly one rising edge; returns 1 time unit after it.
  task automatic doLoad(input logic [1:0] s, input logic [3:0] d);
    @(negedge DIV_CLK);
    setSel(s);
    {DIN3, DIN2, DIN1, DIN0} = d;
    LOAD = 1'b1;
    @(posedge DIV_CLK);
    #1;
    LOAD = 1'b0;
  endtask

  task automatic readNib(input logic [1:0] s, output logic [3:0] v);
    setSel(s);
    #1;
    v = {R3, R2, R1, R0};
  endtask

  task automatic checkResult(input string tag, input logic [7:0] eq, input logic [3:0] er);
    logic [3:0] lo, hi, r;
    readNib(2'd0, lo);
    readNib(2'd1, hi);
    readNib(2'd2, r);
    check({tag, "_q"}, {hi, lo}, eq);
    check({tag, "_rem"}, r, er);
  endtask

  // Counts cycles with BUSY high; bounded so a stuck divider cannot hang the run.
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (BUSY && cycles < 20) begin
      @(posedge DIV_CLK);
      #1;
      cycles++;
    end
  endtask

  task automatic loadDvd(input logic [7:0] v);
    doLoad(2'd0, v[3:0]);
    doLoad(2'd1, v[7:4]);
  endtask

  task automatic runDiv(input string tag, input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] eq, input logic [3:0] er);
    int cyc;
    logic [3:0] st;
    loadDvd(a);
    doLoad(2'd2, b);
    waitDone(cyc);
    check({tag, "_cycles"}, cyc, 8);
    readNib(2'd3, st);
    check({tag, "_status"}, st, 4'h1);
    checkResult(tag, eq, er);
  endtask

  initial begin
    logic [3:0] v;
    int cyc;

    // Reset state: every select reads zero.
    #12;
    for (int s = 0; s < 4; s++) begin
      readNib(s[1:0], v);
      check($sformatf("reset_sel%0d", s), v, 0);
    end
    check("reset_busy", BUSY, 0);
    #3 RST_N = 1'b1;

    // Basic divide and extremes.
    runDiv("basic", 8'hC8, 4'h7, 8'h1C, 4'h4);
    runDiv("ff_1", 8'hFF, 4'h1, 8'hFF, 4'h0);
    runDiv("05_9", 8'h05, 4'h9, 8'h00, 4'h5);
    runDiv("ff_f", 8'hFF, 4'hF, 8'h11, 4'h0);

    // Divide by zero completes on the start edge without ever going busy.
    loadDvd(8'h3A);
    doLoad(2'd2, 4'h0);
    check("dz_busy", BUSY, 0);
    readNib(2'd3, v);
    check("dz_status", v, 4'h5);
    checkResult("dz", 8'hFF, 4'h0);

    // Loads during RUN are dropped, including a second start.
    loadDvd(8'h64);
    doLoad(2'd2, 4'h3);
    repeat (3) @(posedge DIV_CLK);
    #1;
    doLoad(2'd0, 4'hF);
    doLoad(2'd2, 4'h1);
    check("ignore_busy", BUSY, 1);
    waitDone(cyc);
    check("ignore_cycles", cyc, 3);
    checkResult("ignore", 8'h21, 4'h1);
    // Divisor 1 returns DVD itself, exposing whether the low nibble survived.
    doLoad(2'd2, 4'h1);
    waitDone(cyc);
    checkResult("dvd_hold", 8'h64, 4'h0);

    // Asynchronous reset in the middle of RUN.
    loadDvd(8'hC8);
    doLoad(2'd2, 4'h7);
    repeat (4) @(posedge DIV_CLK);
    #3 RST_N = 1'b0;
    #1;
    check("rst_busy", BUSY, 0);
    for (int s = 0; s < 4; s++) begin
      readNib(s[1:0], v);
      check($sformatf("rst_sel%0d", s), v, 0);
    end
    @(negedge DIV_CLK);
    #2 RST_N = 1'b1;
    runDiv("after_rst", 8'h10, 4'h4, 8'h04, 4'h0);

    // Start on E8 is ignored; a start one cycle later is accepted.
    loadDvd(8'h64);
    doLoad(2'd2, 4'h3);
    repeat (7) @(posedge DIV_CLK);
    #1;
    doLoad(2'd2, 4'hF);
    check("b2b_e8_busy", BUSY, 0);
    readNib(2'd3, v);
    check("b2b_e8_status", v, 4'h1);
    checkResult("b2b_first", 8'h21, 4'h1);
    doLoad(2'd2, 4'h5);
    check("b2b_e9_busy", BUSY, 1);
    waitDone(cyc);
    check("b2b_cycles", cyc, 8);
    checkResult("b2b_second", 8'h14, 4'h0);

    // Operand loads after DONE clear the flag but hold the results.
    doLoad(2'd0, 4'h9);
    readNib(2'd3, v);
    check("hold_status", v, 4'h0);
    doLoad(2'd1, 4'h2);
    checkResult("hold", 8'h14, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1);
  end

endmodule
